// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM states, flag bit positions.
package alu_pkg;

  // ALU op codes; 3'b001 and 3'b111 are deliberately absent (illegal).
  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110
  } alu_op_t;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Bit positions inside the {negative, zero, overflow, carryOut} flag vector.
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;
  localparam int NUM_FLAGS  = 4;

  // True for op codes the ALU understands.
  function automatic logic is_legal_op(input logic [2:0] code);
    case (code)
      OP_PASS_B, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant picker: a lone requester always wins, a tie goes
// to the requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Pick a one-hot grant from the request pair and the last-served pointer.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path leaves it unassigned (which would infer a latch).
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU. Each op runs
// IDLE (accept) -> ISSUE (drive ALU, capture result) -> RESP (hold result
// until the granted requester takes it).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_A,
  input  logic [1:0][WIDTH-1:0] req_B,
  input  logic [1:0][2:0]       req_ctrl,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_out,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      alu_A,
  output logic [WIDTH-1:0]      alu_B,
  output logic [2:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_carryOut
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last;        // requester served by the previous completed op
  logic                 r_gnt_idx;     // requester owning the in-flight op
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2:0]           r_ctrl;
  logic [WIDTH-1:0]     r_rsp_out;
  logic [NUM_FLAGS-1:0] r_rsp_flags;
  logic                 r_rsp_err;

  logic [1:0]           w_gnt;
  logic                 w_gnt_idx;
  logic                 w_accept;
  logic                 w_rsp_hs;
  logic                 w_legal;

  rr_arb2 u_rr_arb2 (
    .req  (req_valid),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_gnt_idx = w_gnt[1];
  assign w_accept  = (r_state == ST_IDLE) && (|req_valid);
  // Only the granted requester's ready can complete the response.
  assign w_rsp_hs  = (r_state == ST_RESP) && rsp_ready[r_gnt_idx];
  assign w_legal   = is_legal_op(r_ctrl);

  assign rsp_out   = r_rsp_out;
  assign rsp_flags = r_rsp_flags;
  assign rsp_err   = r_rsp_err;

  // State register; reset abandons any in-flight op.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; requests are not queued, so req_valid matters only in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (|req_valid) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_RESP;
      ST_RESP:  if (rsp_ready[r_gnt_idx]) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs: accept strobe, response valid and the ALU drive.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    alu_A     = '0;
    alu_B     = '0;
    alu_ctrl  = 3'b000;
    case (r_state)
      ST_IDLE: begin
        if (!reset) req_ready = w_gnt;
      end
      ST_ISSUE: begin
        alu_A    = r_a;
        alu_B    = r_b;
        // An illegal code never reaches the ALU; it sees a harmless pass-B.
        alu_ctrl = w_legal ? r_ctrl : OP_PASS_B;
      end
      ST_RESP: begin
        rsp_valid[r_gnt_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand latch on accept and result capture at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_ctrl      <= 3'b000;
      r_gnt_idx   <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a       <= req_A[w_gnt_idx];
        r_b       <= req_B[w_gnt_idx];
        r_ctrl    <= req_ctrl[w_gnt_idx];
        r_gnt_idx <= w_gnt_idx;
      end
      if (r_state == ST_ISSUE) begin
        if (w_legal) begin
          r_rsp_out                <= alu_out;
          r_rsp_flags[FLAG_NEG]    <= alu_negative;
          r_rsp_flags[FLAG_ZERO]   <= alu_zero;
          r_rsp_flags[FLAG_OVF]    <= alu_overflow;
          r_rsp_flags[FLAG_CARRY]  <= alu_carryOut;
          r_rsp_err                <= 1'b0;
        end else begin
          r_rsp_out   <= '0;
          r_rsp_flags <= '0;
          r_rsp_err   <= 1'b1;
        end
      end
    end
  end

  // Round-robin pointer advances only when a response is actually delivered.
  always_ff @(posedge clk) begin
    if (reset)         r_last <= 1'b1;
    else if (w_rsp_hs) r_last <= r_gnt_idx;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter. The bench supplies the
// shared ALU and predicts grants and responses from the arbitration rules.
module tb_alu_arbiter;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] out;
    logic [3:0]   flags;   // {negative, zero, overflow, carryOut}
    logic         err;
  } res_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][W-1:0]    req_A;
  logic [1:0][W-1:0]    req_B;
  logic [1:0][2:0]      req_ctrl;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [W-1:0]         rsp_out;
  logic [3:0]           rsp_flags;
  logic                 rsp_err;
  logic [W-1:0]         alu_A;
  logic [W-1:0]         alu_B;
  logic [2:0]           alu_ctrl;
  logic [W-1:0]         alu_out;
  logic                 alu_negative;
  logic                 alu_zero;
  logic                 alu_overflow;
  logic                 alu_carryOut;

  int n_checks = 0;
  int n_errors = 0;
  int last_served;   // model of the round-robin history

  alu_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_A        (req_A),
    .req_B        (req_B),
    .req_ctrl     (req_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_ctrl     (alu_ctrl),
    .alu_out      (alu_out),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carryOut (alu_carryOut)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each op code; illegal codes yield an error result.
  function automatic res_t model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] op);
    res_t       r;
    logic [W:0] s;
    logic       ovf;
    logic       cy;
    r   = '0;
    s   = '0;
    ovf = 1'b0;
    cy  = 1'b0;
    case (op)
      3'b000: r.out = b;
      3'b010: begin
        s     = {1'b0, a} + {1'b0, b};
        r.out = s[W-1:0];
        cy    = s[W];
        ovf   = (a[W-1] == b[W-1]) && (r.out[W-1] != a[W-1]);
      end
      3'b011: begin
        s     = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        r.out = s[W-1:0];
        cy    = s[W];
        ovf   = (a[W-1] != b[W-1]) && (r.out[W-1] != a[W-1]);
      end
      3'b100: r.out = a & b;
      3'b101: r.out = a | b;
      3'b110: r.out = a ^ b;
      default: begin
        r.err = 1'b1;
        return r;
      end
    endcase
    r.flags = {r.out[W-1], (r.out == '0), ovf, cy};
    return r;
  endfunction

  // The shared combinational ALU seen by the arbiter.
  res_t env_res;
  always_comb env_res = model_alu(alu_A, alu_B, alu_ctrl);
  assign alu_out      = env_res.out;
  assign alu_negative = env_res.flags[3];
  assign alu_zero     = env_res.flags[2];
  assign alu_overflow = env_res.flags[1];
  assign alu_carryOut = env_res.flags[0];

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // One complete op. Entered just after a negedge with the DUT idle and the
  // operands already on req_A/req_B/req_ctrl; returns just after the negedge
  // following the response handshake, with req_valid and rsp_ready dropped.
  task automatic transact(input logic [1:0] mask, input int stall);
    int           gi;
    logic [1:0]   exp_oh;
    logic [W-1:0] a_g;
    logic [W-1:0] b_g;
    logic [2:0]   c_g;
    res_t         exp;
    req_valid = mask;
    rsp_ready = 2'b00;
    #1;
    if (mask == 2'b11) gi = (last_served == 1) ? 0 : 1;
    else               gi = (mask == 2'b10) ? 1 : 0;
    exp_oh = (gi == 1) ? 2'b10 : 2'b01;
    a_g    = req_A[gi];
    b_g    = req_B[gi];
    c_g    = req_ctrl[gi];
    exp    = model_alu(a_g, b_g, c_g);

    // Accept cycle
    n_checks++;
    if (req_ready !== exp_oh) begin
      n_errors++; $display("FAIL accept_ready got %b exp %b", req_ready, exp_oh);
    end
    n_checks++;
    if (rsp_valid !== 2'b00 || alu_ctrl !== 3'b000 || alu_A !== '0 || alu_B !== '0) begin
      n_errors++; $display("FAIL idle_outputs rsp_valid %b alu_ctrl %b alu_A %h alu_B %h exp all zero",
                           rsp_valid, alu_ctrl, alu_A, alu_B);
    end

    // ISSUE cycle: request inputs are scrambled, the ALU must still see the latched op
    @(negedge clk);
    req_valid     = 2'($urandom_range(0, 3));
    req_A[gi]     = rand_word();
    req_B[gi]     = rand_word();
    req_ctrl[gi]  = 3'($urandom_range(0, 7));
    #1;
    n_checks++;
    if (alu_A !== a_g || alu_B !== b_g) begin
      n_errors++; $display("FAIL issue_operands got %h/%h exp %h/%h", alu_A, alu_B, a_g, b_g);
    end
    n_checks++;
    if (alu_ctrl !== (exp.err ? 3'b000 : c_g)) begin
      n_errors++; $display("FAIL issue_ctrl got %b exp %b", alu_ctrl, exp.err ? 3'b000 : c_g);
    end
    n_checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      n_errors++; $display("FAIL issue_strobes req_ready %b rsp_valid %b exp 00 00", req_ready, rsp_valid);
    end

    // RESP: first cycle, then optional stall with only the other requester ready
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      n_checks++;
      if (rsp_valid !== exp_oh) begin
        n_errors++; $display("FAIL rsp_valid cyc %0d got %b exp %b", s, rsp_valid, exp_oh);
      end
      n_checks++;
      if (rsp_out !== exp.out || rsp_flags !== exp.flags || rsp_err !== exp.err) begin
        n_errors++; $display("FAIL rsp_data cyc %0d got %h %b %b exp %h %b %b",
                             s, rsp_out, rsp_flags, rsp_err, exp.out, exp.flags, exp.err);
      end
      n_checks++;
      if (req_ready !== 2'b00 || alu_ctrl !== 3'b000 || alu_A !== '0 || alu_B !== '0) begin
        n_errors++; $display("FAIL resp_quiet req_ready %b alu_ctrl %b alu_A %h alu_B %h exp zero",
                             req_ready, alu_ctrl, alu_A, alu_B);
      end
      if (s < stall) begin
        rsp_ready = ~exp_oh;
        @(negedge clk);
      end
    end
    rsp_ready = exp_oh | (($urandom_range(0, 1) == 1) ? ~exp_oh : 2'b00);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_errors++; $display("FAIL rsp_drop got %b exp 00", rsp_valid);
    end
    last_served = gi;
    req_valid   = 2'b00;
    rsp_ready   = 2'b00;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c);
    req_A[r]    = a;
    req_B[r]    = b;
    req_ctrl[r] = c;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_req(0, rand_word(), rand_word(), 3'b010);
    set_req(1, rand_word(), rand_word(), 3'b011);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
        n_errors++; $display("FAIL reset_strobes req_ready %b rsp_valid %b exp 00 00", req_ready, rsp_valid);
      end
      n_checks++;
      if (alu_A !== '0 || alu_B !== '0 || alu_ctrl !== 3'b000) begin
        n_errors++; $display("FAIL reset_alu got %h %h %b exp zero", alu_A, alu_B, alu_ctrl);
      end
    end
    reset       = 1'b0;
    req_valid   = 2'b00;
    rsp_ready   = 2'b00;
    last_served = 1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00 || rsp_out !== '0 || rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_rsp got %b %h %b %b exp cleared", rsp_valid, rsp_out, rsp_flags, rsp_err);
    end
  endtask

  task automatic test_single();
    set_req(0, 64'd5, 64'd3, 3'b010);
    transact(2'b01, 0);
  endtask

  task automatic test_tie();
    for (int i = 0; i < 3; i++) begin
      set_req(0, rand_word(), rand_word(), 3'b101);
      set_req(1, rand_word(), rand_word(), 3'b110);
      transact(2'b11, i);
    end
  endtask

  task automatic test_sub_zero_backpressure();
    set_req(1, 64'd7, 64'd7, 3'b011);
    transact(2'b10, 4);
  endtask

  task automatic test_illegal();
    set_req(0, rand_word(), rand_word(), 3'b111);
    transact(2'b01, 1);
    set_req(1, rand_word(), rand_word(), 3'b001);
    transact(2'b10, 0);
  endtask

  task automatic test_overflow();
    set_req(0, {1'b0, {(W-1){1'b1}}}, 64'd1, 3'b010);
    transact(2'b01, 0);
  endtask

  task automatic test_reset_in_issue();
    // Requester 0 served last, so only a pointer reset makes 0 win the next tie.
    set_req(0, rand_word(), rand_word(), 3'b100);
    transact(2'b01, 0);
    set_req(1, rand_word(), rand_word(), 3'b010);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_errors++; $display("FAIL rii_accept got %b exp 10", req_ready);
    end
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);
    reset     = 1'b0;
    last_served = 1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rsp_valid !== 2'b00) begin
        n_errors++; $display("FAIL rii_no_rsp cyc %0d got %b exp 00", i, rsp_valid);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b00;
    set_req(0, rand_word(), rand_word(), 3'b011);
    set_req(1, rand_word(), rand_word(), 3'b000);
    transact(2'b11, 0);
  endtask

  task automatic test_random();
    logic [1:0] mask;
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 2; r++) begin
        case ($urandom_range(0, 3))
          0:       set_req(r, rand_word(), rand_word(), 3'($urandom_range(0, 7)));
          1:       set_req(r, {1'b1, 63'($urandom)}, {1'b1, 63'($urandom)}, 3'($urandom_range(2, 3)));
          2:       set_req(r, 64'($urandom_range(0, 3)), 64'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
          default: set_req(r, {1'b0, {(W-1){1'b1}}}, rand_word(), 3'($urandom_range(2, 3)));
        endcase
      end
      mask = 2'($urandom_range(1, 3));
      transact(mask, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_A     = '0;
    req_B     = '0;
    req_ctrl  = '0;
    test_reset();
    test_single();
    test_tie();
    test_sub_zero_backpressure();
    test_illegal();
    test_overflow();
    test_reset_in_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, [1:0], per-requester op request.
REQ-005 SHALL have port req_ready, output, [1:0], per-requester accept strobe.
REQ-006 SHALL have port req_A / req_B, input, [1:0][WIDTH-1:0], per-requester operands.
REQ-007 SHALL have port req_ctrl, input, [1:0][2:0], per-requester ALU op code.
REQ-008 SHALL have port rsp_valid, output, [1:0], per-requester result valid.
REQ-009 SHALL have port rsp_ready, input, [1:0], per-requester result consumed.
REQ-010 SHALL have port rsp_out, output, WIDTH, shared result bus, meaningful only with a rsp_valid bit set.
REQ-011 SHALL have port rsp_flags, output, 4, {negative, zero, overflow, carryOut} of the result.
REQ-012 SHALL have port rsp_err, output, 1, illegal op code flag.
REQ-013 SHALL have ports alu_A / alu_B, output, WIDTH, and alu_ctrl, output, 3, which drive the shared combinational ALU.
REQ-014 SHALL have ports alu_out, input, WIDTH, and alu_negative / alu_zero / alu_overflow / alu_carryOut, input, 1 each, the ALU results.

Function
REQ-015 SHALL use legal ctrl codes 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor; 001 and 111 are illegal.
REQ-016 SHALL implement FSM states IDLE, ISSUE, RESP.
- IDLE -> ISSUE on any req_valid.
- ISSUE -> RESP unconditionally.
- RESP -> IDLE on rsp_valid[g] & rsp_ready[g], where g is the granted requester.
REQ-017 SHALL assert req_ready[g] combinationally only in IDLE, one-hot, for the granted requester g.
REQ-018 SHALL choose g in IDLE as follows:
- only one requester valid: that requester;
- both valid: the requester not served last (round-robin).
REQ-019 SHALL latch req_A[g], req_B[g], req_ctrl[g] and g on the IDLE accept edge.
REQ-020 SHALL, in ISSUE, drive alu_* from the latched operands and capture alu_out and flags at the end of the cycle.
REQ-021 SHALL drive alu_A, alu_B and alu_ctrl to 0 in every state other than ISSUE.
REQ-022 SHALL assert rsp_valid[g] two cycles after the accept edge and hold it, with rsp_out, rsp_flags and rsp_err stable, until rsp_ready[g].
REQ-023 SHALL ignore rsp_ready of the non-granted requester.
REQ-024 SHALL update the round-robin last-served pointer to g on the response handshake.
REQ-025 SHALL, for an illegal ctrl:
- still accept and sequence the op;
- drive alu_ctrl=000 in ISSUE;
- return rsp_out=0, rsp_flags=0, rsp_err=1.
REQ-026 SHALL keep rsp_err=0 for legal ops.
REQ-027 SHALL ignore req_valid changes outside IDLE, with no requests queued; the minimum op period is 3 cycles.

Reset
REQ-028 SHALL, on reset high at a clock edge:
- set state IDLE;
- set the last-served pointer to 1, so requester 0 wins the first tie;
- clear rsp_valid, rsp_out, rsp_flags, rsp_err and the operand latches.
REQ-029 SHALL hold req_ready=0 while reset is high.
REQ-030 SHALL, on reset asserted in ISSUE or RESP, discard the in-flight op with no response delivered.

Structure
REQ-031 SHALL take the op-code constants (alu_op_t), the FSM state enum and the flag bit indices from shared package alu_pkg.
REQ-032 SHALL contain one sub-module, rr_arb2: a two-way round-robin grant picker with inputs req[1:0] and last, and output gnt[1:0] one-hot.

Verification
REQ-033 SHALL cover single request: req_valid=01, A=5, B=3, ctrl=010 -> req_ready=01 in the same cycle; rsp_valid=01 two cycles later; rsp_out=8; flags zero=0.
REQ-034 SHALL cover a tie after reset: req_valid=11 -> requester 0 granted first. With both requests held, requester 1 is granted at the next IDLE and requester 0 at the one after that.
REQ-035 SHALL cover subtract to zero and back-pressure:
- A=B=7, ctrl=011 -> rsp_out=0, zero=1, carryOut=1;
- rsp_ready held 0 for 4 cycles -> rsp_valid and data stable throughout; FSM stays in RESP.
REQ-036 SHALL cover an illegal op: ctrl=111 -> alu_ctrl=000 during ISSUE; response rsp_err=1, rsp_out=0.
REQ-037 SHALL cover reset in ISSUE: reset pulsed one cycle -> no rsp_valid ever for that op; next request served with latency 2; requester 0 wins the next tie.
REQ-038 SHALL cover overflow: A=0x7FFF...F, B=1, ctrl=010 -> rsp_out=0x8000...0, overflow=1, negative=1.
